// File: rtl/or1200_keccak_ctrl_pkg.sv
// Shared constants for the or1200 custom-5 Keccak sequencer: FSM state codes,
// cust5 command encodings, SHA3 pad bytes and the lane geometry.
package or1200_keccak_pkg;

    localparam int NUM_LANES = 25;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ABSORB  = 3'd1;
    localparam state_t ST_PAD     = 3'd2;
    localparam state_t ST_PERMUTE = 3'd3;
    localparam state_t ST_SQUEEZE = 3'd4;

    localparam logic [4:0] CMD_ABSORB  = 5'b00001;
    localparam logic [4:0] CMD_LAST    = 5'b00010;
    localparam logic [4:0] CMD_INIT    = 5'b00100;
    localparam logic [4:0] CMD_SQUEEZE = 5'b01000;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    // A byte count above the word size means "whole word".
    function automatic logic [5:0] clamp_limm(input logic [5:0] limm, input int nbytes);
        logic [5:0] max_v;
        max_v = 6'(nbytes);
        return (limm > max_v) ? max_v : limm;
    endfunction

endpackage

// File: rtl/or1200_keccak_ctrl_if.sv
// Command/status and state-core bus between the or1200 pipeline and the Keccak
// sequencer; master is the pipeline side, slave is the sequencer.
interface or1200_keccak_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int HASH_W = 8
);
    import or1200_keccak_pkg::*;

    logic              cmd_valid;
    logic [4:0]        cust5_op;
    logic [5:0]        cust5_limm;
    logic [WIDTH-1:0]  a;
    logic              busy;
    logic              lane_we;
    logic [LANE_W-1:0] lane_idx;
    logic [WIDTH-1:0]  lane_data;
    logic              keccak_en;
    logic [4:0]        round_idx;
    logic              in_ready;
    logic              is_last;
    logic              out32;
    logic [HASH_W-1:0] hash_num;

    modport master (
        output cmd_valid, cust5_op, cust5_limm, a,
        input  busy, lane_we, lane_idx, lane_data, keccak_en, round_idx,
        input  in_ready, is_last, out32, hash_num
    );

    modport slave (
        input  cmd_valid, cust5_op, cust5_limm, a,
        output busy, lane_we, lane_idx, lane_data, keccak_en, round_idx,
        output in_ready, is_last, out32, hash_num
    );

endinterface

// File: rtl/or1200_keccak_ctrl_pad.sv
// Combinational byte mask for LAST words and, with KECCAK_CTRL_PAD_EN defined,
// the SHA3 pad10*1 word generator (0x06 after the data, 0x80 in the top rate byte).
module or1200_keccak_pad
    import or1200_keccak_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RATE_WORDS = 18
) (
    input  logic [WIDTH-1:0]  data_in,
    input  logic [5:0]        limm,
`ifdef KECCAK_CTRL_PAD_EN
    input  logic [LANE_W-1:0] lane,
    output logic [LANE_W-1:0] pad_lane,
    output logic [WIDTH-1:0]  pad_word,
    output logic              pad_single,
`endif
    output logic [WIDTH-1:0]  data_out
);

    localparam int NBYTES = WIDTH / 8;

    logic [5:0] limm_c_s;

    assign limm_c_s = clamp_limm(limm, NBYTES);

    // Zero every byte at or above the valid byte count
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NBYTES; i++) begin
            data_out[8*i +: 8] = (6'(i) < limm_c_s) ? data_in[8*i +: 8] : 8'h00;
        end
    end

`ifdef KECCAK_CTRL_PAD_EN
    logic       wrap_s;
    logic [5:0] byte_pos_s;

    // A full final word pushes the 0x06 byte into byte 0 of the next lane
    assign wrap_s     = (limm_c_s == 6'(NBYTES));
    assign byte_pos_s = wrap_s ? 6'd0 : limm_c_s;
    assign pad_lane   = lane + LANE_W'(wrap_s);
    assign pad_single = (pad_lane == LANE_W'(RATE_WORDS - 1));

    // Build the first pad word, merging the 0x80 byte when both share a lane
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < NBYTES; i++) begin
            pad_word[8*i +: 8] = (6'(i) == byte_pos_s) ? PAD_FIRST : 8'h00;
        end
        pad_word[WIDTH-1 -: 8] = pad_word[WIDTH-1 -: 8] | (pad_single ? PAD_LAST : 8'h00);
    end
`endif

endmodule

// File: rtl/or1200_keccak_ctrl.sv
// Keccak absorb/permute/squeeze sequencer behind the or1200 l.cust5 decode.
// Optional hardware SHA3 padding is built when KECCAK_CTRL_PAD_EN is defined.
module or1200_keccak_ctrl
    import or1200_keccak_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RATE_WORDS = 18,
    parameter int OUT_WORDS  = 16,
    parameter int ROUNDS     = 24,
    parameter int HASH_W     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    or1200_keccak_ctrl_if.slave bus
);

    state_t            state_r, state_s;
    logic [LANE_W-1:0] wcnt_r, wcnt_s;
    logic [LANE_W-1:0] scnt_r, scnt_s;
    logic [5:0]        rcnt_r, rcnt_s;
    logic              is_last_r, is_last_s;
    logic [HASH_W-1:0] hash_r, hash_s;

    logic              we_s, en_s;
    logic [LANE_W-1:0] idx_s;
    logic [WIDTH-1:0]  data_s, masked_s;
    logic [4:0]        ridx_s;

    logic              lane_we_r, keccak_en_r, in_ready_r, out32_r, busy_r;
    logic [LANE_W-1:0] lane_idx_r;
    logic [WIDTH-1:0]  lane_data_r;
    logic [4:0]        round_idx_r;

    logic init_s, absorb_s, last_s, squeeze_s;

    assign init_s    = bus.cmd_valid && (bus.cust5_op == CMD_INIT);
    assign absorb_s  = bus.cmd_valid && (bus.cust5_op == CMD_ABSORB);
    assign last_s    = bus.cmd_valid && (bus.cust5_op == CMD_LAST);
    assign squeeze_s = bus.cmd_valid && (bus.cust5_op == CMD_SQUEEZE);

`ifdef KECCAK_CTRL_PAD_EN
    logic [LANE_W-1:0] pad_lane_r, pad_lane_s;
    logic [WIDTH-1:0]  pad_word_r, pad_word_s;
    logic              pad_single_r, pad_single_s;
    logic              pad_phase_r, pad_phase_s;
`endif

    or1200_keccak_pad #(
        .WIDTH      (WIDTH),
        .RATE_WORDS (RATE_WORDS)
    ) u_pad (
        .data_in    (bus.a),
        .limm       (bus.cust5_limm),
`ifdef KECCAK_CTRL_PAD_EN
        .lane       (wcnt_r),
        .pad_lane   (pad_lane_s),
        .pad_word   (pad_word_s),
        .pad_single (pad_single_s),
`endif
        .data_out   (masked_s)
    );

    // Next-state and per-cycle lane/round strobes; INIT overrides every state
    always_comb begin
        state_s   = state_r;
        wcnt_s    = wcnt_r;
        scnt_s    = scnt_r;
        rcnt_s    = rcnt_r;
        is_last_s = is_last_r;
        hash_s    = hash_r;
        we_s      = 1'b0;
        idx_s     = '0;
        data_s    = '0;
        en_s      = 1'b0;
        ridx_s    = 5'd0;
`ifdef KECCAK_CTRL_PAD_EN
        pad_phase_s = pad_phase_r;
`endif
        if (init_s) begin
            state_s   = ST_ABSORB;
            wcnt_s    = '0;
            scnt_s    = '0;
            rcnt_s    = 6'd0;
            is_last_s = 1'b0;
`ifdef KECCAK_CTRL_PAD_EN
            pad_phase_s = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ABSORB: begin
                    if (absorb_s) begin
                        we_s   = 1'b1;
                        idx_s  = wcnt_r;
                        data_s = bus.a;
                        wcnt_s = wcnt_r + LANE_W'(1'b1);
                        if (wcnt_r == LANE_W'(RATE_WORDS - 1)) begin
                            state_s   = ST_PERMUTE;
                            is_last_s = 1'b0;
                        end else begin
                            state_s = ST_ABSORB;
                        end
                    end else if (last_s) begin
                        we_s      = 1'b1;
                        idx_s     = wcnt_r;
                        data_s    = masked_s;
                        is_last_s = 1'b1;
`ifdef KECCAK_CTRL_PAD_EN
                        state_s     = ST_PAD;
                        pad_phase_s = 1'b0;
`else
                        state_s = ST_PERMUTE;
`endif
                    end else begin
                        state_s = ST_ABSORB;
                    end
                end
`ifdef KECCAK_CTRL_PAD_EN
                ST_PAD: begin
                    we_s = 1'b1;
                    if (!pad_phase_r) begin
                        idx_s  = pad_lane_r;
                        data_s = pad_word_r;
                        if (pad_single_r) begin
                            state_s = ST_PERMUTE;
                        end else begin
                            pad_phase_s = 1'b1;
                        end
                    end else begin
                        idx_s       = LANE_W'(RATE_WORDS - 1);
                        data_s      = {PAD_LAST, {(WIDTH-8){1'b0}}};
                        pad_phase_s = 1'b0;
                        state_s     = ST_PERMUTE;
                    end
                end
`endif
                // First PERMUTE cycle lets the last lane write land before round 0
                ST_PERMUTE: begin
                    if (rcnt_r == 6'(ROUNDS)) begin
                        state_s = is_last_r ? ST_SQUEEZE : ST_ABSORB;
                        wcnt_s  = '0;
                        scnt_s  = '0;
                        rcnt_s  = 6'd0;
                    end else begin
                        en_s   = 1'b1;
                        ridx_s = rcnt_r[4:0];
                        rcnt_s = rcnt_r + 6'd1;
                    end
                end
                ST_SQUEEZE: begin
                    if (squeeze_s) begin
                        idx_s  = scnt_r;
                        scnt_s = scnt_r + LANE_W'(1'b1);
                        if (scnt_r == LANE_W'(OUT_WORDS - 1)) begin
                            hash_s  = hash_r + HASH_W'(1'b1);
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_SQUEEZE;
                        end
                    end else begin
                        state_s = ST_SQUEEZE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wcnt_r      <= '0;
            scnt_r      <= '0;
            rcnt_r      <= 6'd0;
            is_last_r   <= 1'b0;
            hash_r      <= '0;
            lane_we_r   <= 1'b0;
            lane_idx_r  <= '0;
            lane_data_r <= '0;
            keccak_en_r <= 1'b0;
            round_idx_r <= 5'd0;
            in_ready_r  <= 1'b0;
            out32_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            wcnt_r      <= wcnt_s;
            scnt_r      <= scnt_s;
            rcnt_r      <= rcnt_s;
            is_last_r   <= is_last_s;
            hash_r      <= hash_s;
            lane_we_r   <= we_s;
            lane_idx_r  <= idx_s;
            lane_data_r <= data_s;
            keccak_en_r <= en_s;
            round_idx_r <= ridx_s;
            in_ready_r  <= (state_s == ST_ABSORB);
            out32_r     <= (state_s == ST_SQUEEZE);
            busy_r      <= (state_s == ST_PAD) || (state_s == ST_PERMUTE);
        end
    end

`ifdef KECCAK_CTRL_PAD_EN
    // Pad geometry is frozen when LAST is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_lane_r   <= '0;
            pad_word_r   <= '0;
            pad_single_r <= 1'b0;
            pad_phase_r  <= 1'b0;
        end else begin
            pad_phase_r <= pad_phase_s;
            if ((state_r == ST_ABSORB) && last_s && !init_s) begin
                pad_lane_r   <= pad_lane_s;
                pad_word_r   <= pad_word_s;
                pad_single_r <= pad_single_s;
            end
        end
    end
`endif

    assign bus.busy      = busy_r;
    assign bus.lane_we   = lane_we_r;
    assign bus.lane_idx  = lane_idx_r;
    assign bus.lane_data = lane_data_r;
    assign bus.keccak_en = keccak_en_r;
    assign bus.round_idx = round_idx_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.is_last   = is_last_r;
    assign bus.out32     = out32_r;
    assign bus.hash_num  = hash_r;

endmodule

// File: tb/tb_or1200_keccak_ctrl.sv
// Directed bench for or1200_keccak_ctrl at default parameters; pad-specific
// expectations follow KECCAK_CTRL_PAD_EN.
module tb_or1200_keccak_ctrl;

    localparam logic [4:0] OP_ABSORB  = 5'b00001;
    localparam logic [4:0] OP_LAST    = 5'b00010;
    localparam logic [4:0] OP_INIT    = 5'b00100;
    localparam logic [4:0] OP_SQUEEZE = 5'b01000;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    or1200_keccak_ctrl_if #(.WIDTH(32), .HASH_W(8)) bus ();

    or1200_keccak_ctrl #(
        .WIDTH      (32),
        .RATE_WORDS (18),
        .OUT_WORDS  (16),
        .ROUNDS     (24),
        .HASH_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] d);
        bus.cmd_valid  = 1'b1;
        bus.cust5_op   = op;
        bus.cust5_limm = limm;
        bus.a          = d;
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b0;
        bus.cust5_op   = 5'd0;
        bus.cust5_limm = 6'd0;
        bus.a          = 32'd0;
    endtask

    task automatic wait_out32(input string tag);
        int k;
        k = 0;
        while (!bus.out32 && k < 40) begin
            step();
            k++;
        end
        check(tag, {63'd0, bus.out32}, 64'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cust5_op   = 5'd0;
        bus.cust5_limm = 6'd0;
        bus.a          = 32'd0;
        repeat (3) step();

        // Reset state
        check("rst_lane_we",   {63'd0, bus.lane_we},   64'd0);
        check("rst_lane_idx",  {59'd0, bus.lane_idx},  64'd0);
        check("rst_lane_data", {32'd0, bus.lane_data}, 64'd0);
        check("rst_keccak_en", {63'd0, bus.keccak_en}, 64'd0);
        check("rst_round_idx", {59'd0, bus.round_idx}, 64'd0);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("rst_is_last",   {63'd0, bus.is_last},   64'd0);
        check("rst_out32",     {63'd0, bus.out32},     64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_hash_num",  {56'd0, bus.hash_num},  64'd0);
        rst_n = 1'b1;
        step();

        // Commands other than INIT are ignored in IDLE
        cmd(OP_ABSORB, 6'd0, 32'h1234_5678);
        check("idle_absorb_we", {63'd0, bus.lane_we},  64'd0);
        check("idle_in_ready",  {63'd0, bus.in_ready}, 64'd0);

        cmd(OP_INIT, 6'd0, 32'd0);
        check("init_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("init_no_write", {63'd0, bus.lane_we},  64'd0);

        // Full non-final block
        for (int i = 0; i < 18; i++) begin
            cmd(OP_ABSORB, 6'd0, 32'(i + 1));
            check("blk_we",   {63'd0, bus.lane_we},   64'd1);
            check("blk_idx",  {59'd0, bus.lane_idx},  64'(i));
            check("blk_data", {32'd0, bus.lane_data}, 64'(i + 1));
        end
        check("blk_busy",     {63'd0, bus.busy},      64'd1);
        check("blk_in_ready", {63'd0, bus.in_ready},  64'd0);
        check("blk_en_late",  {63'd0, bus.keccak_en}, 64'd0);
        for (int r = 0; r < 24; r++) begin
            if (r == 5) begin
                cmd(OP_ABSORB, 6'd0, 32'hDEAD_BEEF);
            end else begin
                step();
            end
            check("perm_en",      {63'd0, bus.keccak_en}, 64'd1);
            check("perm_round",   {59'd0, bus.round_idx}, 64'(r));
            check("perm_dropped", {63'd0, bus.lane_we},   64'd0);
        end
        step();
        check("perm_end_en",  {63'd0, bus.keccak_en}, 64'd0);
        check("perm_ready",   {63'd0, bus.in_ready},  64'd1);
        check("perm_is_last", {63'd0, bus.is_last},   64'd0);

        // Final partial block
        for (int i = 0; i < 3; i++) begin
            cmd(OP_ABSORB, 6'd0, 32'h0000_0100 + 32'(i));
        end
        cmd(OP_LAST, 6'd2, 32'hAABB_CCDD);
        check("last_idx",     {59'd0, bus.lane_idx},  64'd3);
        check("last_data",    {32'd0, bus.lane_data}, 64'h0000_CCDD);
        check("last_is_last", {63'd0, bus.is_last},   64'd1);
        check("last_busy",    {63'd0, bus.busy},      64'd1);
`ifdef KECCAK_CTRL_PAD_EN
        step();
        check("pad06_we",   {63'd0, bus.lane_we},   64'd1);
        check("pad06_idx",  {59'd0, bus.lane_idx},  64'd3);
        check("pad06_data", {32'd0, bus.lane_data}, 64'h0006_0000);
        step();
        check("pad80_idx",  {59'd0, bus.lane_idx},  64'd17);
        check("pad80_data", {32'd0, bus.lane_data}, 64'h8000_0000);
`endif
        for (int r = 0; r < 24; r++) begin
            step();
            check("fin_round", {59'd0, bus.round_idx}, 64'(r));
        end
        step();
        check("fin_out32",    {63'd0, bus.out32},    64'd1);
        check("fin_in_ready", {63'd0, bus.in_ready}, 64'd0);

        // Squeeze the digest
        for (int i = 0; i < 16; i++) begin
            cmd(OP_SQUEEZE, 6'd0, 32'd0);
            check("sq_idx", {59'd0, bus.lane_idx}, 64'(i));
            check("sq_we",  {63'd0, bus.lane_we},  64'd0);
            if (i == 14) begin
                check("sq_hash_before", {56'd0, bus.hash_num}, 64'd0);
            end
        end
        check("sq_hash_after", {56'd0, bus.hash_num}, 64'd1);
        check("sq_out32_off",  {63'd0, bus.out32},    64'd0);
        cmd(OP_SQUEEZE, 6'd0, 32'd0);
        check("idle_after_sq", {63'd0, bus.out32}, 64'd0);

        // INIT in the middle of a permutation
        cmd(OP_INIT, 6'd0, 32'd0);
        for (int i = 0; i < 18; i++) begin
            cmd(OP_ABSORB, 6'd0, 32'(i));
        end
        repeat (11) step();
        check("mid_round10", {59'd0, bus.round_idx}, 64'd10);
        cmd(OP_INIT, 6'd0, 32'd0);
        check("mid_init_ready", {63'd0, bus.in_ready},  64'd1);
        check("mid_init_en",    {63'd0, bus.keccak_en}, 64'd0);
        check("mid_init_busy",  {63'd0, bus.busy},      64'd0);
        check("mid_init_hash",  {56'd0, bus.hash_num},  64'd1);
        cmd(OP_ABSORB, 6'd0, 32'h0000_0055);
        check("mid_init_wcnt0", {59'd0, bus.lane_idx}, 64'd0);

        // Clamped LAST at lane 16, then reset mid-permutation
        for (int i = 1; i < 16; i++) begin
            cmd(OP_ABSORB, 6'd0, 32'(i));
        end
        cmd(OP_LAST, 6'd63, 32'hCAFE_F00D);
        check("clamp_idx",  {59'd0, bus.lane_idx},  64'd16);
        check("clamp_data", {32'd0, bus.lane_data}, 64'hCAFE_F00D);
`ifdef KECCAK_CTRL_PAD_EN
        step();
        check("padnext_idx",  {59'd0, bus.lane_idx},  64'd17);
        check("padnext_data", {32'd0, bus.lane_data}, 64'h8000_0006);
`endif
        repeat (11) step();
        check("rst_mid_en", {63'd0, bus.keccak_en}, 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstmid_en",    {63'd0, bus.keccak_en}, 64'd0);
        check("rstmid_round", {59'd0, bus.round_idx}, 64'd0);
        check("rstmid_busy",  {63'd0, bus.busy},      64'd0);
        check("rstmid_ready", {63'd0, bus.in_ready},  64'd0);
        check("rstmid_hash",  {56'd0, bus.hash_num},  64'd0);
        check("rstmid_last",  {63'd0, bus.is_last},   64'd0);

        // 256 complete hashes wrap the counter
        for (int h = 0; h < 256; h++) begin
            cmd(OP_INIT, 6'd0, 32'd0);
            for (int i = 0; i < 17; i++) begin
                cmd(OP_ABSORB, 6'd0, 32'(i));
            end
            cmd(OP_LAST, 6'd3, 32'h1122_3344);
            if (h == 0) begin
                check("wrap_last_data", {32'd0, bus.lane_data}, 64'h0022_3344);
            end
`ifdef KECCAK_CTRL_PAD_EN
            step();
            if (h == 0) begin
                check("pad86_idx",  {59'd0, bus.lane_idx},  64'd17);
                check("pad86_data", {32'd0, bus.lane_data}, 64'h8600_0000);
            end
            step();
            if (h == 0) begin
                check("pad86_single", {63'd0, bus.lane_we}, 64'd0);
            end
`endif
            wait_out32("wrap_perm_done");
            for (int i = 0; i < 16; i++) begin
                cmd(OP_SQUEEZE, 6'd0, 32'd0);
            end
            if (h == 254) begin
                check("wrap_hash_255", {56'd0, bus.hash_num}, 64'd255);
            end
        end
        check("wrap_hash_0", {56'd0, bus.hash_num}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_keccak_ctrl.md
# or1200_keccak_ctrl

Parametrised Keccak sequencer behind the or1200 ALU custom-5 (`l.cust5`) decode. It turns `cust5_op` commands into lane writes, timed permutation rounds and squeeze reads for an external Keccak-f state/round core. It generalises the fixed 32-bit ALU hook to configurable word width, rate and digest length. It adds a real absorb/permute/squeeze state machine with pipeline stall and a completed-hash counter.

## Interface
Parameters:
- WIDTH, 32: data word width; 32 or 64.
- RATE_WORDS, 18: words per rate block (18 = SHA3-512 at 32 bit).
- OUT_WORDS, 16: digest words per hash; must be ≤ RATE_WORDS.
- ROUNDS, 24: permutation rounds.
- HASH_W, 8: width of the hash counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  custom-5 instruction issued this cycle.
- cust5_op  in  5  command, one-hot: 00100 INIT, 00001 ABSORB, 00010 LAST, 01000 SQUEEZE; any other value is a NOP.
- cust5_limm  in  6  LAST only: valid byte count in `a`, 0..WIDTH/8.
- a  in  WIDTH  data word for ABSORB/LAST.
- busy  out  1  stall request to the pipeline.
- lane_we  out  1  XOR `lane_data` into state lane `lane_idx`.
- lane_idx  out  $clog2(25)  lane index; for squeeze, the lane to read.
- lane_data  out  WIDTH  word to XOR.
- keccak_en  out  1  round enable to the core.
- round_idx  out  5  current round, 0..ROUNDS-1.
- in_ready  out  1  ABSORB/LAST accepted.
- is_last  out  1  the current block is the final block.
- out32  out  1  digest available; SQUEEZE accepted.
- hash_num  out  HASH_W  count of completed hashes, wraps.

## Operation
States: IDLE, ABSORB, PAD, PERMUTE, SQUEEZE.

- **IDLE**
  - INIT moves to ABSORB and clears the word counter, squeeze counter and `is_last`.
  - Other commands are ignored.
- **ABSORB** (`in_ready`=1)
  - ABSORB writes `a` to lane `wcnt`, then increments `wcnt`.
  - When `wcnt` reaches RATE_WORDS, go to PERMUTE with `is_last`=0.
  - LAST writes the masked `a` (bytes ≥ `cust5_limm` zeroed), sets `is_last`, then:
    - goes to PAD if PAD_EN is defined;
    - otherwise goes to PERMUTE.
- **PAD**: see Configuration. Then go to PERMUTE.
- **PERMUTE**
  - `keccak_en`=1 for exactly ROUNDS cycles; `round_idx` counts 0..ROUNDS-1; `busy`=1.
  - After the last round:
    - if `is_last`, go to SQUEEZE;
    - otherwise go to ABSORB with `wcnt`=0.
- **SQUEEZE** (`out32`=1)
  - Each SQUEEZE command drives `lane_idx`=`scnt` (core returns the lane on the ALU result path), then increments `scnt`.
  - After OUT_WORDS reads, `hash_num` increments and the block returns to IDLE.
- **Priority and illegal commands**
  - INIT has priority in every state: next state ABSORB, counters cleared, no lane write, `hash_num` kept.
  - Commands illegal for the current state are NOPs; no error is flagged.
  - `busy` is high in PAD and PERMUTE; commands arriving then are dropped, since the pipeline is stalled.
- **LAST edge cases**
  - LAST arriving when `wcnt`=RATE_WORDS-1 is legal.
  - `cust5_limm` > WIDTH/8 is clamped to WIDTH/8.

## Timing
- All outputs are registered. An accepted command's `lane_we`/`lane_idx`/`lane_data` appear the cycle after `cmd_valid`.
- A full block is RATE_WORDS accepted ABSORBs. The first `keccak_en` comes one cycle after the last `lane_we`.
- Permutation latency is exactly ROUNDS cycles. `in_ready` or `out32` rises the cycle after `round_idx`=ROUNDS-1.
- Reset values: all outputs 0, state IDLE. Reset mid-permutation aborts immediately and zeroes `hash_num`.
- `hash_num` wraps from 2^HASH_W-1 to 0.

## Configuration
- KECCAK_CTRL_PAD_EN defined: hardware SHA3 pad10*1. PAD state issues:
  - a 0x06 byte at byte `cust5_limm` of lane `wcnt` (next lane if `cust5_limm`=WIDTH/8);
  - a 0x80 top byte at lane RATE_WORDS-1.
  - If both land in the same lane, one write carries 0x86.
  - PAD lasts 1 or 2 cycles.
- Undefined: no PAD state; software supplies padding; LAST goes straight to PERMUTE.

## Structure
- Package `or1200_keccak_pkg`:
  - state enum;
  - cust5 command encodings;
  - pad constants 0x06 and 0x80;
  - lane count 25.
- One sub-module is natural: `or1200_keccak_pad`, a combinational byte-mask/pad-merge unit.

## Test plan
- **Reset and init:** rst_n low → all outputs 0. INIT → `in_ready`=1 next cycle.
- **Non-final block:** 18 ABSORBs of 0x00000001..0x00000012 → `lane_idx` 0..17 with matching data. Then `keccak_en` for 24 cycles, `round_idx` 0..23, then `in_ready`=1 and `is_last`=0.
- **Pad, partial word (PAD_EN):** LAST at `wcnt`=3, `a`=0xAABBCCDD, `cust5_limm`=2 → lane 3 gets 0x0000CCDD, then 0x00060000. Lane 17 gets 0x80000000. 24 rounds follow, then `out32`=1.
- **Squeeze:** 16 SQUEEZEs → `lane_idx` 0..15. `hash_num` goes 0→1, then IDLE.
- **Mid-permutation events:** INIT at round 10 → ABSORB, `wcnt`=0, `hash_num` unchanged. rst_n low at round 10 → outputs 0, state IDLE.
- **Dropped commands and wrap:** ABSORB during PERMUTE → no `lane_we`. 256 complete hashes with HASH_W=8 → `hash_num` wraps to 0.
